// File: rtl/view_upd_if.sv
// View-parameter update channel: valid/ready handshake carrying one zoom/pan offer.
interface view_upd_if #(
  parameter int ADDR_W = 23,
  parameter int X_W    = 10,
  parameter int Y_W    = 9
) ();
  logic              upd_valid;
  logic              upd_ready;
  logic [7:0]        scale_factor;
  logic [9:0]        scale_width;
  logic [X_W-1:0]    x_offset;
  logic [Y_W-1:0]    y_offset;
  logic [ADDR_W-1:0] base_addr;

  modport master (
    output upd_valid, scale_factor, scale_width, x_offset, y_offset, base_addr,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, scale_factor, scale_width, x_offset, y_offset, base_addr,
    output upd_ready
  );
endinterface

// File: rtl/view_frame_sync.sv
// Double-buffered view settings committed at frame start, plus per-frame and
// per-line SDRAM read start addresses and registered sync leading-edge pulses.
//
// state   | meaning
// ST_IDLE | pending slot free, ready high
// ST_CALC | offer captured, pending address being computed
// ST_PEND | pending update complete, waits for the next frame edge
module view_frame_sync #(
  parameter int HOR_SIZE     = 2560,
  parameter int HOR_PITCH    = 256,
  parameter int ADDR_W       = 23,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int FINE_W       = 6,
  parameter int SYNC_STAGES  = 3,
  parameter bit SYNC_ACT_LOW = 1'b1,
  parameter int LINE_W       = 10
) (
  input  logic              iCLK,
  input  logic              iRSTN,
  input  logic              iVS,
  input  logic              iHS,
  view_upd_if.slave         upd,
  output logic [7:0]        oSCALE_FACTOR,
  output logic [9:0]        oSCALE_WIDTH,
  output logic [FINE_W:0]   oFINE_OFFSET,
  output logic [ADDR_W-1:0] oFRAME_ADDR,
  output logic [ADDR_W-1:0] oLINE_ADDR,
  output logic [LINE_W-1:0] oLINE_CNT,
  output logic              oFRAME_START,
  output logic              oLINE_START,
  output logic              oCOMMIT
);
  localparam logic              ACT_LVL    = ~SYNC_ACT_LOW;
  localparam logic              INACT_LVL  = SYNC_ACT_LOW;
  localparam logic [ADDR_W-1:0] HOR_SIZE_A = ADDR_W'(HOR_SIZE);
  localparam logic [ADDR_W-1:0] PITCH_A    = ADDR_W'(HOR_PITCH);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_PEND} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] vs_q, vs_d, hs_q, hs_d;
  logic [7:0]             cap_factor_q, cap_factor_d;
  logic [9:0]             cap_width_q, cap_width_d;
  logic [X_W-1:0]         cap_x_q, cap_x_d;
  logic [Y_W-1:0]         cap_y_q, cap_y_d;
  logic [ADDR_W-1:0]      cap_base_q, cap_base_d;
  logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
  logic [7:0]             factor_q, factor_d;
  logic [9:0]             width_q, width_d;
  logic [FINE_W-1:0]      fine_q, fine_d;
  logic [ADDR_W-1:0]      frame_addr_q, frame_addr_d;
  logic [ADDR_W-1:0]      line_addr_q, line_addr_d;
  logic [LINE_W-1:0]      line_cnt_q, line_cnt_d;
  logic                   frame_start_q, frame_start_d;
  logic                   line_start_q, line_start_d;
  logic                   commit_q, commit_d;
  logic                   frame_edge, line_edge;
  logic [ADDR_W-1:0]      y_term, x_term;

  assign frame_edge = (vs_q[SYNC_STAGES-2] == ACT_LVL) && (vs_q[SYNC_STAGES-1] == INACT_LVL);
  assign line_edge  = (hs_q[SYNC_STAGES-2] == ACT_LVL) && (hs_q[SYNC_STAGES-1] == INACT_LVL);

  // Products come from captured registers, so the commit path is only a mux.
  assign y_term = HOR_SIZE_A * ADDR_W'(cap_y_q);
  assign x_term = PITCH_A * ADDR_W'(cap_x_q[X_W-1:FINE_W]);

  always_comb begin
    state_d       = state_q;
    vs_d          = {vs_q[SYNC_STAGES-2:0], iVS};
    hs_d          = {hs_q[SYNC_STAGES-2:0], iHS};
    cap_factor_d  = cap_factor_q;
    cap_width_d   = cap_width_q;
    cap_x_d       = cap_x_q;
    cap_y_d       = cap_y_q;
    cap_base_d    = cap_base_q;
    pend_addr_d   = pend_addr_q;
    factor_d      = factor_q;
    width_d       = width_q;
    fine_d        = fine_q;
    frame_addr_d  = frame_addr_q;
    line_addr_d   = line_addr_q;
    line_cnt_d    = line_cnt_q;
    frame_start_d = frame_edge;
    line_start_d  = line_edge;
    commit_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (upd.upd_valid) begin
          cap_factor_d = upd.scale_factor;
          cap_width_d  = upd.scale_width;
          cap_x_d      = upd.x_offset;
          cap_y_d      = upd.y_offset;
          cap_base_d   = upd.base_addr;
          state_d      = ST_CALC;
        end
      end
      ST_CALC: begin
        pend_addr_d = cap_base_q + y_term + x_term;
        state_d     = ST_PEND;
      end
      ST_PEND: begin
        if (frame_edge) begin
          factor_d     = cap_factor_q;
          width_d      = cap_width_q;
          fine_d       = cap_x_q[FINE_W-1:0];
          frame_addr_d = pend_addr_q;
          commit_d     = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame edge takes priority over a coincident line edge.
    if (frame_edge) begin
      line_addr_d = frame_addr_d;
      line_cnt_d  = '0;
    end else if (line_edge) begin
      line_addr_d = line_addr_q + HOR_SIZE_A;
      if (line_cnt_q != '1) line_cnt_d = line_cnt_q + LINE_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q       <= ST_IDLE;
      vs_q          <= {SYNC_STAGES{INACT_LVL}};
      hs_q          <= {SYNC_STAGES{INACT_LVL}};
      cap_factor_q  <= '0;
      cap_width_q   <= '0;
      cap_x_q       <= '0;
      cap_y_q       <= '0;
      cap_base_q    <= '0;
      pend_addr_q   <= '0;
      factor_q      <= 8'h80;
      width_q       <= 10'd800;
      fine_q        <= '0;
      frame_addr_q  <= '0;
      line_addr_q   <= '0;
      line_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      commit_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      hs_q          <= hs_d;
      cap_factor_q  <= cap_factor_d;
      cap_width_q   <= cap_width_d;
      cap_x_q       <= cap_x_d;
      cap_y_q       <= cap_y_d;
      cap_base_q    <= cap_base_d;
      pend_addr_q   <= pend_addr_d;
      factor_q      <= factor_d;
      width_q       <= width_d;
      fine_q        <= fine_d;
      frame_addr_q  <= frame_addr_d;
      line_addr_q   <= line_addr_d;
      line_cnt_q    <= line_cnt_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      commit_q      <= commit_d;
    end
  end

  assign upd.upd_ready = (state_q == ST_IDLE);
  assign oSCALE_FACTOR = factor_q;
  assign oSCALE_WIDTH  = width_q;
  assign oFINE_OFFSET  = {1'b0, fine_q};
  assign oFRAME_ADDR   = frame_addr_q;
  assign oLINE_ADDR    = line_addr_q;
  assign oLINE_CNT     = line_cnt_q;
  assign oFRAME_START  = frame_start_q;
  assign oLINE_START   = line_start_q;
  assign oCOMMIT       = commit_q;
endmodule

// File: tb/tb_view_frame_sync.sv
// Bench for view_frame_sync: directed scenarios plus random traffic, all
// outputs compared every cycle against an event-history reference model.
module tb_view_frame_sync;
  localparam int S = 3;
  localparam bit ACT = 1'b0;
  localparam int HLEN = 16384;

  logic        iCLK = 1'b0;
  logic        iRSTN;
  logic        iVS, iHS;
  logic [7:0]  oSCALE_FACTOR;
  logic [9:0]  oSCALE_WIDTH;
  logic [6:0]  oFINE_OFFSET;
  logic [22:0] oFRAME_ADDR, oLINE_ADDR;
  logic [9:0]  oLINE_CNT;
  logic        oFRAME_START, oLINE_START, oCOMMIT;

  view_upd_if #(.ADDR_W(23), .X_W(10), .Y_W(9)) upd_if ();

  view_frame_sync dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iVS(iVS), .iHS(iHS), .upd(upd_if.slave),
    .oSCALE_FACTOR(oSCALE_FACTOR), .oSCALE_WIDTH(oSCALE_WIDTH),
    .oFINE_OFFSET(oFINE_OFFSET), .oFRAME_ADDR(oFRAME_ADDR),
    .oLINE_ADDR(oLINE_ADDR), .oLINE_CNT(oLINE_CNT),
    .oFRAME_START(oFRAME_START), .oLINE_START(oLINE_START), .oCOMMIT(oCOMMIT)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw sync sample history indexed by clock edge since reset.
  bit vs_hist [HLEN];
  bit hs_hist [HLEN];
  int e;
  bit m_ready, m_pend, m_fs, m_ls, m_commit;
  int m_acc_e;
  logic [7:0]  m_p_factor, m_factor;
  logic [9:0]  m_p_width, m_width;
  logic [5:0]  m_p_fine, m_fine;
  logic [22:0] m_p_addr, m_frame_addr, m_line_addr;
  int          m_line_cnt;

  function automatic bit vs_at(input int idx);
    return (idx < 1) ? ~ACT : vs_hist[idx];
  endfunction
  function automatic bit hs_at(input int idx);
    return (idx < 1) ? ~ACT : hs_hist[idx];
  endfunction

  task automatic model_reset();
    e = 0; m_ready = 1; m_pend = 0; m_acc_e = 0;
    m_fs = 0; m_ls = 0; m_commit = 0;
    m_factor = 8'h80; m_width = 10'd800; m_fine = 0;
    m_frame_addr = 0; m_line_addr = 0; m_line_cnt = 0;
  endtask

  task automatic model_step();
    bit acc;
    longint a;
    e++;
    if (e >= HLEN) $fatal(1, "FAIL history: bench history overflow");
    vs_hist[e] = iVS;
    hs_hist[e] = iHS;
    // Leading edge is visible S-1 samples later and its pulse one edge after that.
    m_fs = (vs_at(e - S + 1) == ACT) && (vs_at(e - S) != ACT);
    m_ls = (hs_at(e - S + 1) == ACT) && (hs_at(e - S) != ACT);
    m_commit = m_fs && m_pend && (e >= m_acc_e + 2);
    acc = upd_if.upd_valid && m_ready;
    if (m_commit) begin
      m_factor = m_p_factor; m_width = m_p_width; m_fine = m_p_fine;
      m_frame_addr = m_p_addr; m_pend = 0; m_ready = 1;
    end
    if (acc) begin
      a = longint'(upd_if.base_addr) + 2560 * longint'(upd_if.y_offset)
          + 256 * longint'(upd_if.x_offset / 64);
      m_p_addr   = a[22:0];
      m_p_factor = upd_if.scale_factor;
      m_p_width  = upd_if.scale_width;
      m_p_fine   = 6'(upd_if.x_offset % 64);
      m_pend = 1; m_ready = 0; m_acc_e = e;
    end
    if (m_fs) begin
      m_line_addr = m_frame_addr;
      m_line_cnt  = 0;
    end else if (m_ls) begin
      m_line_addr = 23'(m_line_addr + 23'd2560);
      if (m_line_cnt < 1023) m_line_cnt++;
    end
  endtask

  task automatic compare_all();
    check("factor",      oSCALE_FACTOR, m_factor);
    check("width",       oSCALE_WIDTH, m_width);
    check("fine",        oFINE_OFFSET, {1'b0, m_fine});
    check("frame_addr",  oFRAME_ADDR, m_frame_addr);
    check("line_addr",   oLINE_ADDR, m_line_addr);
    check("line_cnt",    oLINE_CNT, m_line_cnt);
    check("frame_start", oFRAME_START, m_fs);
    check("line_start",  oLINE_START, m_ls);
    check("commit",      oCOMMIT, m_commit);
    check("ready",       upd_if.upd_ready, m_ready);
  endtask

  task automatic cyc();
    @(posedge iCLK);
    model_step();
    @(negedge iCLK);
    compare_all();
  endtask

  task automatic offer(input logic [7:0] f, input logic [9:0] w, input logic [9:0] x,
                       input logic [8:0] y, input logic [22:0] b);
    upd_if.upd_valid = 1; upd_if.scale_factor = f; upd_if.scale_width = w;
    upd_if.x_offset = x; upd_if.y_offset = y; upd_if.base_addr = b;
  endtask

  task automatic do_reset();
    iRSTN = 0; iVS = 1; iHS = 1; upd_if.upd_valid = 0;
    repeat (2) @(negedge iCLK);
    model_reset();
    compare_all();
    iRSTN = 1;
  endtask

  task automatic vs_pulse();
    iVS = 0; cyc(); iVS = 1; cyc(); cyc();
  endtask

  bit seen_commit;

  initial begin
    iRSTN = 0; iVS = 1; iHS = 1;
    upd_if.upd_valid = 0; upd_if.scale_factor = 0; upd_if.scale_width = 0;
    upd_if.x_offset = 0; upd_if.y_offset = 0; upd_if.base_addr = 0;
    @(negedge iCLK);
    do_reset();
    repeat (5) cyc();
    check("rst_factor", oSCALE_FACTOR, 8'h80);
    check("rst_width", oSCALE_WIDTH, 10'd800);
    check("rst_ready", upd_if.upd_ready, 1);

    // Commit of base 0x1000, Y=2, X=0x85 lands 3 cycles after VS sampled low.
    offer(8'h40, 10'd640, 10'h085, 9'd2, 23'h1000); cyc();
    upd_if.upd_valid = 0; repeat (3) cyc();
    vs_pulse();
    check("c1_commit", oCOMMIT, 1);
    check("c1_fstart", oFRAME_START, 1);
    check("c1_addr", oFRAME_ADDR, 23'h2600);
    check("c1_fine", oFINE_OFFSET, 7'd5);
    check("c1_ready", upd_if.upd_ready, 1);

    repeat (4) begin iHS = 0; cyc(); iHS = 1; cyc(); end
    cyc();
    check("hs4_cnt", oLINE_CNT, 10'd4);
    check("hs4_addr", oLINE_ADDR, 23'h4E00);
    vs_pulse();
    check("reload_addr", oLINE_ADDR, 23'h2600);
    check("reload_cnt", oLINE_CNT, 10'd0);

    // Accept on the very edge that registers the frame pulse.
    iVS = 0; cyc(); iVS = 1; cyc();
    offer(8'h20, 10'd320, 10'h041, 9'd3, 23'h20000); cyc();
    upd_if.upd_valid = 0;
    check("same_commit", oCOMMIT, 0);
    check("same_ready", upd_if.upd_ready, 0);
    check("same_addr", oFRAME_ADDR, 23'h2600);
    repeat (4) cyc();
    vs_pulse();
    check("next_commit", oCOMMIT, 1);
    check("next_addr", oFRAME_ADDR, 23'h21F00);

    // Address wrap and simultaneous VS/HS edges.
    offer(8'h10, 10'd100, 10'h000, 9'd1, 23'h7FFF00); cyc();
    upd_if.upd_valid = 0; repeat (3) cyc();
    iVS = 0; iHS = 0; cyc(); iVS = 1; iHS = 1; cyc(); cyc();
    check("wrap_addr", oFRAME_ADDR, 23'h000900);
    check("wrap_line", oLINE_ADDR, 23'h000900);
    check("wrap_cnt", oLINE_CNT, 10'd0);
    check("wrap_lstart", oLINE_START, 1);

    repeat (1030) begin iHS = 0; cyc(); iHS = 1; cyc(); end
    cyc();
    check("sat_cnt", oLINE_CNT, 10'd1023);

    // Reset while an update is pending discards it.
    offer(8'h55, 10'd500, 10'h0C3, 9'd7, 23'h123456); cyc();
    upd_if.upd_valid = 0; repeat (2) cyc();
    do_reset();
    check("rp_factor", oSCALE_FACTOR, 8'h80);
    check("rp_addr", oFRAME_ADDR, 0);
    seen_commit = 0;
    iVS = 0; cyc(); seen_commit |= oCOMMIT;
    iVS = 1;
    repeat (4) begin cyc(); seen_commit |= oCOMMIT; end
    check("rp_nocommit", seen_commit, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      if (upd_if.upd_valid && !upd_if.upd_ready) begin
        // hold the offer stable while waiting
      end else if ($urandom_range(0, 3) == 0)
        offer(8'($urandom), 10'($urandom), 10'($urandom), 9'($urandom), 23'($urandom));
      else
        upd_if.upd_valid = 0;
      iVS = (iVS == 1'b0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) != 0);
      iHS = (iHS == 1'b0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
